// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the MAR/MBR memory responder.
package mem_resp_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Even parity bit: makes the total count of ones even. Callers zero-extend.
    function automatic logic even_par(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/mem_resp_array.sv
// Word storage: synchronous write, registered read; maps onto block RAM.
module mem_resp_array #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 16,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic             re,
    input  logic [IDX_W-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// Handshaked memory responder for the CPU MAR/MBR bus with fixed read wait states.
// Optional parity storage and error injection with MEM_RESP_PARITY_EN.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
`ifdef MEM_RESP_PARITY_EN
    input  logic              err_inject,
`endif
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] LAT_M1 = (RD_LAT == 0) ? 4'd0 : 4'(RD_LAT - 1);
`ifdef MEM_RESP_PARITY_EN
    localparam int RAM_W = DATA_W + 1;
`else
    localparam int RAM_W = DATA_W;
`endif

    state_t            state, state_nx;
    logic [3:0]        cnt;
    logic              cap_we, cap_in;
    logic              accept, in_range;
    logic [RAM_W-1:0]  ram_wdata, ram_q;
    logic              rd_ok;

    assign accept   = req_valid && req_ready;
    assign in_range = 32'(req_addr) < 32'(DEPTH);

`ifdef MEM_RESP_PARITY_EN
    assign ram_wdata = {even_par(64'(req_wdata)) ^ err_inject, req_wdata};
`else
    assign ram_wdata = req_wdata;
`endif

    mem_resp_array #(.DEPTH(DEPTH), .WIDTH(RAM_W), .IDX_W(IDX_W)) u_array (
        .clk   (clk),
        .we    (accept && req_we && in_range),
        .re    (accept && !req_we && in_range),
        .addr  (req_addr[IDX_W-1:0]),
        .wdata (ram_wdata),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            cap_we <= 1'b0;
            cap_in <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                cap_we <= req_we;
                cap_in <= in_range;
                if (!req_we) cnt <= LAT_M1;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        req_ready = 1'b1;
        case (state)
            IDLE, RESP: begin
                if (accept)
                    state_nx = (req_we || RD_LAT == 0) ? RESP : WAIT;
                else
                    state_nx = IDLE;
            end
            WAIT: begin
                req_ready = 1'b0;
                if (cnt == 4'd0) state_nx = RESP;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Data is only meaningful for an in-range read response; everything else reads as 0.
    assign rsp_valid = (state == RESP);
    assign busy      = (state == WAIT);
    assign rd_ok     = rsp_valid && !cap_we && cap_in;
    assign rsp_rdata = rd_ok ? ram_q[DATA_W-1:0] : '0;

`ifdef MEM_RESP_PARITY_EN
    assign rsp_err = rd_ok && (ram_q[DATA_W] ^ even_par(64'(ram_q[DATA_W-1:0])));
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed, table-driven bench for mem_responder (DEPTH=128, RD_LAT=2).
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic        req_ready, rsp_valid, rsp_err, busy;
    logic [15:0] rsp_rdata;
`ifdef MEM_RESP_PARITY_EN
    logic        err_inject;
`endif

    int checks = 0;
    int errors = 0;
    int rsp_cnt = 0;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(8), .DATA_W(16), .DEPTH(128), .RD_LAT(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
`ifdef MEM_RESP_PARITY_EN
        .err_inject(err_inject),
`endif
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    typedef struct {
        logic        v;
        logic        we;
        logic [7:0]  a;
        logic [15:0] d;
        logic        e_vld;
        logic [15:0] e_dat;
        logic        e_rdy;
        logic        e_bsy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic we, logic [7:0] a, logic [15:0] d,
                                logic e_vld, logic [15:0] e_dat, logic e_rdy, logic e_bsy);
        vec_t r;
        r.v = v; r.we = we; r.a = a; r.d = d;
        r.e_vld = e_vld; r.e_dat = e_dat; r.e_rdy = e_rdy; r.e_bsy = e_bsy;
        return r;
    endfunction

    // Shorthands for the expected-response shapes used by the table.
    function automatic vec_t w_ack(logic [7:0] a, logic [15:0] d);
        return mk(1, 1, a, d, 1, 16'h0, 1, 0);
    endfunction
    function automatic vec_t rd(logic [7:0] a);
        return mk(1, 0, a, 16'h0, 0, 16'h0, 0, 1);
    endfunction
    function automatic vec_t wt();
        return mk(0, 0, 8'h0, 16'h0, 0, 16'h0, 0, 1);
    endfunction
    function automatic vec_t rsp(logic [15:0] d);
        return mk(0, 0, 8'h0, 16'h0, 1, d, 1, 0);
    endfunction
    function automatic vec_t idl();
        return mk(0, 0, 8'h0, 16'h0, 0, 16'h0, 1, 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic we, input logic [7:0] a,
                       input logic [15:0] d, input logic inj);
        req_valid = v; req_we = we; req_addr = a; req_wdata = d;
`ifdef MEM_RESP_PARITY_EN
        err_inject = inj;
`endif
        @(posedge clk);
        #1;
        if (rsp_valid) rsp_cnt++;
    endtask

    task automatic chk_out(input string tag, input logic vld, input logic [15:0] dat,
                           input logic rdy, input logic bsy, input logic err);
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(vld));
        chk({tag, ".rsp_rdata"}, 32'(rsp_rdata), 32'(dat));
        chk({tag, ".req_ready"}, 32'(req_ready), 32'(rdy));
        chk({tag, ".busy"},      32'(busy),      32'(bsy));
        chk({tag, ".rsp_err"},   32'(rsp_err),   32'(err));
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
`ifdef MEM_RESP_PARITY_EN
        err_inject = 0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 0, 16'h0, 1, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        tbl.push_back(w_ack(8'h10, 16'hBEEF));
        tbl.push_back(rd(8'h10)); tbl.push_back(wt()); tbl.push_back(rsp(16'hBEEF));
        tbl.push_back(idl());
        tbl.push_back(w_ack(8'h01, 16'h1111)); tbl.push_back(w_ack(8'h02, 16'h2222));
        tbl.push_back(w_ack(8'h03, 16'h3333)); tbl.push_back(w_ack(8'h04, 16'h4444));
        tbl.push_back(rd(8'h01));
        // Read of 0x02 held while WAIT: ignored twice, then accepted once in RESP.
        tbl.push_back(mk(1, 0, 8'h02, 16'h0, 0, 16'h0,    0, 1));
        tbl.push_back(mk(1, 0, 8'h02, 16'h0, 1, 16'h1111, 1, 0));
        tbl.push_back(rd(8'h02)); tbl.push_back(wt()); tbl.push_back(rsp(16'h2222));
        tbl.push_back(rd(8'h03)); tbl.push_back(wt()); tbl.push_back(rsp(16'h3333));
        tbl.push_back(rd(8'h04)); tbl.push_back(wt()); tbl.push_back(rsp(16'h4444));
        tbl.push_back(idl());
        tbl.push_back(w_ack(8'h7F, 16'h5A5A)); tbl.push_back(w_ack(8'h80, 16'h1234));
        tbl.push_back(rd(8'h80)); tbl.push_back(wt()); tbl.push_back(rsp(16'h0000));
        tbl.push_back(rd(8'h7F)); tbl.push_back(wt()); tbl.push_back(rsp(16'h5A5A));
        tbl.push_back(w_ack(8'h20, 16'hCAFE));
        tbl.push_back(rd(8'h20)); tbl.push_back(wt()); tbl.push_back(rsp(16'hCAFE));
        tbl.push_back(idl());

        rsp_cnt = 0;
        foreach (tbl[i]) begin
            cyc(tbl[i].v, tbl[i].we, tbl[i].a, tbl[i].d, 1'b0);
            chk_out($sformatf("row%0d", i), tbl[i].e_vld, tbl[i].e_dat,
                    tbl[i].e_rdy, tbl[i].e_bsy, 1'b0);
        end
        chk("rsp_count", 32'(rsp_cnt), 32'd16);

        // Reset in the middle of WAIT: abort the read, keep the earlier write.
        cyc(1, 1, 8'h30, 16'h7777, 0);
        chk_out("rst_wr", 1, 16'h0, 1, 0, 0);
        cyc(1, 0, 8'h30, 16'h0, 0);
        chk_out("rst_wait", 0, 16'h0, 0, 1, 0);
        req_valid = 0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("rst_async", 0, 16'h0, 1, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_cnt = 0;
        for (int i = 0; i < 3; i++) cyc(0, 0, 8'h0, 16'h0, 0);
        chk("rst_no_rsp", 32'(rsp_cnt), 32'd0);
        cyc(1, 0, 8'h30, 16'h0, 0);
        cyc(0, 0, 8'h0, 16'h0, 0);
        cyc(0, 0, 8'h0, 16'h0, 0);
        chk_out("rst_rd", 1, 16'h7777, 1, 0, 0);
        cyc(0, 0, 8'h0, 16'h0, 0);

`ifdef MEM_RESP_PARITY_EN
        cyc(1, 1, 8'h40, 16'h00FF, 1);
        chk_out("par_wr_inj", 1, 16'h0, 1, 0, 0);
        cyc(1, 0, 8'h40, 16'h0, 0);
        cyc(0, 0, 8'h0, 16'h0, 0);
        cyc(0, 0, 8'h0, 16'h0, 0);
        chk_out("par_rd_bad", 1, 16'h00FF, 1, 0, 1);
        cyc(1, 1, 8'h40, 16'h00FF, 0);
        chk_out("par_wr_ok", 1, 16'h0, 1, 0, 0);
        cyc(1, 0, 8'h40, 16'h0, 0);
        cyc(0, 0, 8'h0, 16'h0, 0);
        cyc(0, 0, 8'h0, 16'h0, 0);
        chk_out("par_rd_ok", 1, 16'h00FF, 1, 0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU's MAR/MBR bus; the CPU initiates, this block completes each transfer.
- Accepts one read or write request at a time, applies a fixed read wait-state count, and returns read data or a write acknowledge as a one-cycle pulse.
- Sits between the CPU datapath and the word-addressed main store, replacing the bare memory macro so that multi-cycle memory is handshaked rather than timed by clock division.

Parameters:
- ADDR_W, 8, address width (matches MAR).
- DATA_W, 16, word width (matches MBR).
- DEPTH, 256, implemented words, 1..2^ADDR_W.
- RD_LAT, 2, read wait-state cycles, 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address (from MAR).
- req_wdata  in  DATA_W  write data (from MBR).
- req_ready  out  1  request can be accepted this cycle.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid.
- rsp_err  out  1  parity error, valid with rsp_valid (0 without PARITY_EN).
- busy  out  1  a request is outstanding (state != IDLE and not in RESP).

Behaviour:
- Reset (async assert, sync release): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, wait counter=0. Array contents are not reset.
- Accept occurs on a rising edge where req_valid && req_ready. Address, we and wdata are captured at that edge.
- FSM states IDLE, WAIT, RESP:
  - IDLE: req_ready=1. Read accept -> WAIT (or RESP if RD_LAT=0). Write accept -> RESP.
  - WAIT: req_ready=0, busy=1. Counter loads RD_LAT-1 at accept and decrements each cycle. At 0 -> RESP.
  - RESP: rsp_valid=1 for exactly this cycle; req_ready=1. Accept in RESP follows the same transitions as IDLE. No accept -> IDLE.
- Write: the array is written at the accept edge. Ack (rsp_valid) occurs in cycle accept+1, independent of RD_LAT. rsp_rdata=0 for a write ack.
- Read: rsp_valid occurs in cycle accept+1+RD_LAT. Data is the array content at the accept edge, with read-after-write ordering: a read accepted after a write's accept returns the new value.
- rsp_rdata is driven to 0 whenever rsp_valid=0.
- Peak throughput: writes 1 per cycle; reads 1 per RD_LAT+1 cycles.
- req_valid while req_ready=0: ignored. The initiator must hold the request until accepted.
- Out of range (req_addr >= DEPTH): write is dropped but still acked; read returns 0 with rsp_err=0.
- Address wraps nothing. There is no burst and no increment.
- Reset mid-WAIT: the request is aborted and no rsp_valid is issued. A write accepted before the reset edge remains committed.

Optional Feature:
- Macro: MEM_RESP_PARITY_EN.
- Defined:
  - The array stores DATA_W+1 bits; the extra bit is the even parity of the data, computed at write.
  - On read, rsp_err = stored parity XOR recomputed parity.
  - An extra input err_inject (1 bit) is present; when high at a write accept, the stored parity bit is inverted.
- Undefined: no parity storage, no err_inject port, rsp_err tied 0.

Decomposition:
- Package mem_resp_pkg: ADDR_W/DATA_W defaults, state enum {IDLE, WAIT, RESP}, and the parity function.
- One sub-module, mem_resp_array:
  - DEPTH x (DATA_W[+1]) storage.
  - Synchronous write and registered read, inferable as block RAM.
- The FSM, counter and range check live in mem_responder.

Test Plan:
- Reset release, then write addr 0x10 = 0xBEEF -> rsp_valid at accept+1 with rdata 0. Then read 0x10 with RD_LAT=2 -> rsp_valid at accept+3, rdata 0xBEEF, ready low for exactly 2 cycles.
- Back-to-back writes 0x01..0x04 on consecutive cycles, then reads -> each write acked next cycle, ready never drops, reads return the written values in order.
- req_valid held during WAIT with a different address -> ignored until RESP, then accepted exactly once. Response count equals request count.
- DEPTH=128: write 0x80=0x1234, then read 0x80 -> ack issued, read returns 0x0000. Read 0x7F returns its prior value.
- Assert rst_n low in the middle of WAIT -> outputs reset immediately, no rsp_valid. A write accepted before reset is readable afterward.
- With MEM_RESP_PARITY_EN: write 0x00FF with err_inject=1, then read -> rsp_err=1, rdata 0x00FF. Rewrite with err_inject=0 -> rsp_err=0.
